// File: rtl/pcie_axi_id_remapper.sv
// pcie_axi_id_remapper
// AXI ID width adapter between the SoC-side AXI port (SlvIdWidth-bit IDs) and
// the XDMA AXI port (MstIdWidth-bit IDs). Only ID fields and channel
// handshakes pass through here; payload fields are routed by the wrapper.
//
// Narrow master side (SlvIdWidth > MstIdWidth): each direction keeps a table
// of outstanding SoC IDs. The master ID is the table index. Same-ID requests
// share one entry so their ordering is preserved.
// Wide master side: IDs are zero-extended outward, truncated on return.
//
// Handshake rule for every channel: a transfer happens on a rising clk edge
// where valid and ready are both high. A master-side valid never depends on
// the master-side ready.
//
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   slv_aw_* / mst_aw_*        write address ID + handshake (SoC -> PCIe)
//   mst_b_*  / slv_b_*         write response ID + handshake (PCIe -> SoC)
//   slv_ar_* / mst_ar_*        read address ID + handshake (SoC -> PCIe)
//   mst_r_*  / slv_r_*         read data ID + handshake, mst_r_last_i ends burst
//   busy_o                     some table entry is in use

// One direction's remap table: request side allocates/hits an entry, the
// response side looks the SoC ID back up and retires on the final beat.
module pcie_axi_id_remapper_table #(
  parameter int SlvIdWidth   = 8,
  parameter int MstIdWidth   = 4,
  parameter int MaxUniqIds   = 16,
  parameter int MaxTxnsPerId = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [SlvIdWidth-1:0] req_id,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [MstIdWidth-1:0] issue_id,
  input  logic                  rsp_valid,
  output logic                  rsp_ready,
  input  logic [MstIdWidth-1:0] rsp_id,
  input  logic                  rsp_last,
  output logic                  ret_valid,
  input  logic                  ret_ready,
  output logic [SlvIdWidth-1:0] ret_id,
  output logic                  busy
);

  localparam int CntW = $clog2(MaxTxnsPerId + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxTxnsPerId);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [MaxUniqIds-1:0] used;
  logic [SlvIdWidth-1:0] slv_id [MaxUniqIds];
  logic [CntW-1:0]       cnt    [MaxUniqIds];

  logic                  hit;
  logic [MstIdWidth-1:0] hit_idx;
  logic                  free_found;
  logic [MstIdWidth-1:0] free_idx;
  logic                  can_issue;
  logic                  req_hs;
  logic                  ret_hs;
  logic [MaxUniqIds-1:0] inc;
  logic [MaxUniqIds-1:0] dec;

  // Lookup works on registered state only, so an entry freed this cycle is
  // not visible as free until the next one.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < MaxUniqIds; i++) begin
      if (!hit && used[i] && (slv_id[i] == req_id)) begin
        hit     = 1'b1;
        hit_idx = MstIdWidth'(i);
      end
    end
    // Descending scan so the lowest free index is the one left standing.
    for (int i = MaxUniqIds - 1; i >= 0; i--) begin
      if (!used[i]) begin
        free_found = 1'b1;
        free_idx   = MstIdWidth'(i);
      end
    end
  end

  // A hitting ID must reuse its entry (or stall) -- never take a second one.
  assign can_issue   = ~rst & (hit ? (cnt[hit_idx] < CntMax) : free_found);
  assign issue_id    = hit ? hit_idx : free_idx;
  assign issue_valid = req_valid & can_issue;
  assign req_ready   = issue_ready & can_issue;

  assign ret_valid = rsp_valid & ~rst;
  assign rsp_ready = ret_ready & ~rst;
  assign ret_id    = slv_id[rsp_id];

  assign req_hs = req_valid & req_ready;
  assign ret_hs = rsp_valid & rsp_ready & rsp_last;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < MaxUniqIds; i++) begin
      inc[i] = req_hs & (issue_id == MstIdWidth'(i));
      dec[i] = ret_hs & (rsp_id == MstIdWidth'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      used <= '0;
      for (int i = 0; i < MaxUniqIds; i++) begin
        cnt[i]    <= '0;
        slv_id[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MaxUniqIds; i++) begin
        // Issue and retire on the same entry cancel; the entry stays used.
        if (inc[i] && !dec[i]) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else if (dec[i] && !inc[i]) begin
          cnt[i] <= cnt[i] - 1'b1;
          if (cnt[i] == CntOne) used[i] <= 1'b0;
        end
        if (inc[i] && !hit) begin
          used[i]   <= 1'b1;
          slv_id[i] <= req_id;
        end
      end
    end
  end

  assign busy = |used;

  // Returned IDs must refer to an entry that is outstanding (which also
  // rules out count underflow, since used implies cnt > 0).
  a_rsp_used : assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && rsp_ready) |-> used[rsp_id]);
  a_cnt_nonzero : assert property (@(posedge clk) disable iff (rst)
    ret_hs |-> (cnt[rsp_id] != '0));
  a_table_fits : assert property (@(posedge clk)
    MaxUniqIds <= (1 << MstIdWidth));

endmodule

module pcie_axi_id_remapper #(
  parameter int SlvIdWidth   = 8,
  parameter int MstIdWidth   = 4,
  parameter int MaxUniqIds   = 16,
  parameter int MaxTxnsPerId = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  slv_aw_valid_i,
  output logic                  slv_aw_ready_o,
  input  logic [SlvIdWidth-1:0] slv_aw_id_i,
  output logic                  mst_aw_valid_o,
  input  logic                  mst_aw_ready_i,
  output logic [MstIdWidth-1:0] mst_aw_id_o,
  input  logic                  mst_b_valid_i,
  output logic                  mst_b_ready_o,
  input  logic [MstIdWidth-1:0] mst_b_id_i,
  output logic                  slv_b_valid_o,
  input  logic                  slv_b_ready_i,
  output logic [SlvIdWidth-1:0] slv_b_id_o,
  input  logic                  slv_ar_valid_i,
  output logic                  slv_ar_ready_o,
  input  logic [SlvIdWidth-1:0] slv_ar_id_i,
  output logic                  mst_ar_valid_o,
  input  logic                  mst_ar_ready_i,
  output logic [MstIdWidth-1:0] mst_ar_id_o,
  input  logic                  mst_r_valid_i,
  output logic                  mst_r_ready_o,
  input  logic [MstIdWidth-1:0] mst_r_id_i,
  input  logic                  mst_r_last_i,
  output logic                  slv_r_valid_o,
  input  logic                  slv_r_ready_i,
  output logic [SlvIdWidth-1:0] slv_r_id_o,
  output logic                  busy_o
);

  if (SlvIdWidth <= MstIdWidth) begin : g_pass
    // Master side is wide enough: no state, pure wiring.
    logic unused_pass;
    assign unused_pass = ^{clk_i, rst_i, mst_r_last_i};

    assign mst_aw_valid_o = slv_aw_valid_i;
    assign slv_aw_ready_o = mst_aw_ready_i;
    assign mst_aw_id_o    = MstIdWidth'(slv_aw_id_i);
    assign slv_b_valid_o  = mst_b_valid_i;
    assign mst_b_ready_o  = slv_b_ready_i;
    assign slv_b_id_o     = mst_b_id_i[SlvIdWidth-1:0];
    assign mst_ar_valid_o = slv_ar_valid_i;
    assign slv_ar_ready_o = mst_ar_ready_i;
    assign mst_ar_id_o    = MstIdWidth'(slv_ar_id_i);
    assign slv_r_valid_o  = mst_r_valid_i;
    assign mst_r_ready_o  = slv_r_ready_i;
    assign slv_r_id_o     = mst_r_id_i[SlvIdWidth-1:0];
    assign busy_o         = 1'b0;
  end else begin : g_remap
    logic w_busy;
    logic r_busy;

    pcie_axi_id_remapper_table #(
      .SlvIdWidth  (SlvIdWidth),
      .MstIdWidth  (MstIdWidth),
      .MaxUniqIds  (MaxUniqIds),
      .MaxTxnsPerId(MaxTxnsPerId)
    ) u_wr_table (
      .clk        (clk_i),
      .rst        (rst_i),
      .req_valid  (slv_aw_valid_i),
      .req_ready  (slv_aw_ready_o),
      .req_id     (slv_aw_id_i),
      .issue_valid(mst_aw_valid_o),
      .issue_ready(mst_aw_ready_i),
      .issue_id   (mst_aw_id_o),
      .rsp_valid  (mst_b_valid_i),
      .rsp_ready  (mst_b_ready_o),
      .rsp_id     (mst_b_id_i),
      .rsp_last   (1'b1),
      .ret_valid  (slv_b_valid_o),
      .ret_ready  (slv_b_ready_i),
      .ret_id     (slv_b_id_o),
      .busy       (w_busy)
    );

    pcie_axi_id_remapper_table #(
      .SlvIdWidth  (SlvIdWidth),
      .MstIdWidth  (MstIdWidth),
      .MaxUniqIds  (MaxUniqIds),
      .MaxTxnsPerId(MaxTxnsPerId)
    ) u_rd_table (
      .clk        (clk_i),
      .rst        (rst_i),
      .req_valid  (slv_ar_valid_i),
      .req_ready  (slv_ar_ready_o),
      .req_id     (slv_ar_id_i),
      .issue_valid(mst_ar_valid_o),
      .issue_ready(mst_ar_ready_i),
      .issue_id   (mst_ar_id_o),
      .rsp_valid  (mst_r_valid_i),
      .rsp_ready  (mst_r_ready_o),
      .rsp_id     (mst_r_id_i),
      .rsp_last   (mst_r_last_i),
      .ret_valid  (slv_r_valid_o),
      .ret_ready  (slv_r_ready_i),
      .ret_id     (slv_r_id_o),
      .busy       (r_busy)
    );

    assign busy_o = w_busy | r_busy;
  end

endmodule

// File: tb/tb_pcie_axi_id_remapper.sv
// Self-checking bench for pcie_axi_id_remapper in remap mode (8-bit SoC IDs,
// 4-bit PCIe IDs, 16 entries, 8 transactions per entry).
// Inputs are driven on the falling edge; outputs are sampled 1 ns later or at
// the falling edge, well away from the rising edge the DUT uses.
module tb_pcie_axi_id_remapper;

  logic       clk;
  logic       rst;
  logic       slv_aw_valid, slv_aw_ready;
  logic [7:0] slv_aw_id;
  logic       mst_aw_valid, mst_aw_ready;
  logic [3:0] mst_aw_id;
  logic       mst_b_valid, mst_b_ready;
  logic [3:0] mst_b_id;
  logic       slv_b_valid, slv_b_ready;
  logic [7:0] slv_b_id;
  logic       slv_ar_valid, slv_ar_ready;
  logic [7:0] slv_ar_id;
  logic       mst_ar_valid, mst_ar_ready;
  logic [3:0] mst_ar_id;
  logic       mst_r_valid, mst_r_ready, mst_r_last;
  logic [3:0] mst_r_id;
  logic       slv_r_valid, slv_r_ready;
  logic [7:0] slv_r_id;
  logic       busy;

  pcie_axi_id_remapper dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .slv_aw_valid_i(slv_aw_valid),
    .slv_aw_ready_o(slv_aw_ready),
    .slv_aw_id_i   (slv_aw_id),
    .mst_aw_valid_o(mst_aw_valid),
    .mst_aw_ready_i(mst_aw_ready),
    .mst_aw_id_o   (mst_aw_id),
    .mst_b_valid_i (mst_b_valid),
    .mst_b_ready_o (mst_b_ready),
    .mst_b_id_i    (mst_b_id),
    .slv_b_valid_o (slv_b_valid),
    .slv_b_ready_i (slv_b_ready),
    .slv_b_id_o    (slv_b_id),
    .slv_ar_valid_i(slv_ar_valid),
    .slv_ar_ready_o(slv_ar_ready),
    .slv_ar_id_i   (slv_ar_id),
    .mst_ar_valid_o(mst_ar_valid),
    .mst_ar_ready_i(mst_ar_ready),
    .mst_ar_id_o   (mst_ar_id),
    .mst_r_valid_i (mst_r_valid),
    .mst_r_ready_o (mst_r_ready),
    .mst_r_id_i    (mst_r_id),
    .mst_r_last_i  (mst_r_last),
    .slv_r_valid_o (slv_r_valid),
    .slv_r_ready_i (slv_r_ready),
    .slv_r_id_o    (slv_r_id),
    .busy_o        (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];     // expected mst AW/AR ids
  logic [7:0] exp_b_q[$];   // expected slv B ids
  logic [7:0] exp_r_q[$];   // expected slv R ids
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    slv_aw_valid = 0; slv_aw_id = '0; mst_aw_ready = 0;
    mst_b_valid = 0; mst_b_id = '0; slv_b_ready = 0;
    slv_ar_valid = 0; slv_ar_id = '0; mst_ar_ready = 0;
    mst_r_valid = 0; mst_r_id = '0; mst_r_last = 0; slv_r_ready = 0;
  endtask

  // ---------------- driver tasks (start and end on a falling edge) ----------------
  task automatic aw_issue(input logic [7:0] id, input logic [7:0] exp_idx);
    bit done = 0;
    exp_q.push_back(exp_idx);
    slv_aw_valid = 1; slv_aw_id = id; mst_aw_ready = 1;
    for (int n = 0; n < 16 && !done; n++) begin
      #1;
      if (slv_aw_ready && mst_aw_valid) begin
        check("aw_id", {4'h0, mst_aw_id}, exp_q.pop_front());
        done = 1;
      end
      @(negedge clk);
    end
    if (!done) begin
      check("aw_timeout", 0, 1);
      void'(exp_q.pop_front());
    end
    slv_aw_valid = 0; mst_aw_ready = 0;
  endtask

  task automatic ar_issue(input logic [7:0] id, input logic [7:0] exp_idx);
    bit done = 0;
    exp_q.push_back(exp_idx);
    slv_ar_valid = 1; slv_ar_id = id; mst_ar_ready = 1;
    for (int n = 0; n < 16 && !done; n++) begin
      #1;
      if (slv_ar_ready && mst_ar_valid) begin
        check("ar_id", {4'h0, mst_ar_id}, exp_q.pop_front());
        done = 1;
      end
      @(negedge clk);
    end
    if (!done) begin
      check("ar_timeout", 0, 1);
      void'(exp_q.pop_front());
    end
    slv_ar_valid = 0; mst_ar_ready = 0;
  endtask

  task automatic b_ret(input logic [3:0] mid, input logic [7:0] exp_slv);
    exp_b_q.push_back(exp_slv);
    mst_b_valid = 1; mst_b_id = mid; slv_b_ready = 1;
    #1;
    if (slv_b_valid && mst_b_ready) check("b_id", slv_b_id, exp_b_q.pop_front());
    else begin
      check("b_handshake", {slv_b_valid, mst_b_ready}, 2'b11);
      void'(exp_b_q.pop_front());
    end
    @(negedge clk);
    mst_b_valid = 0; slv_b_ready = 0;
  endtask

  task automatic r_beat(input logic [3:0] mid, input logic last, input logic [7:0] exp_slv);
    exp_r_q.push_back(exp_slv);
    mst_r_valid = 1; mst_r_id = mid; mst_r_last = last; slv_r_ready = 1;
    #1;
    if (slv_r_valid && mst_r_ready) check("r_id", slv_r_id, exp_r_q.pop_front());
    else begin
      check("r_handshake", {slv_r_valid, mst_r_ready}, 2'b11);
      void'(exp_r_q.pop_front());
    end
    @(negedge clk);
    mst_r_valid = 0; mst_r_last = 0; slv_r_ready = 0;
  endtask

  // Called at a falling edge: busy is registered, so it is stable here.
  task automatic busy_chk(input string tag, input logic exp);
    check(tag, busy, exp);
  endtask

  task automatic aw_stall_chk(input string tag);
    check({tag, "_ready"}, slv_aw_ready, 0);
    check({tag, "_valid"}, mst_aw_valid, 0);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] seen[$];
  logic [7:0] rid_q[$];
  logic [7:0] ridx_q[$];

  initial begin
    clear_inputs();
    rst = 1;
    @(negedge clk);
    // Outputs held low during reset even with requests pending.
    slv_aw_valid = 1; mst_aw_ready = 1; slv_aw_id = 8'h12;
    #1;
    aw_stall_chk("rst_aw");
    busy_chk("rst_busy", 0);
    @(negedge clk);
    clear_inputs();
    rst = 0;
    @(negedge clk);
    busy_chk("idle_busy", 0);

    // 1: single write
    aw_issue(8'hA5, 0);
    busy_chk("t1_busy_on", 1);
    b_ret(0, 8'hA5);
    busy_chk("t1_busy_off", 0);

    // 2: shared entry for a repeated ID
    aw_issue(8'h11, 0);
    aw_issue(8'h11, 0);
    aw_issue(8'h22, 1);
    b_ret(1, 8'h22);
    busy_chk("t2_busy_a", 1);
    b_ret(0, 8'h11);
    busy_chk("t2_busy_b", 1);
    b_ret(0, 8'h11);
    busy_chk("t2_busy_off", 0);

    // 3: table full, then a freed slot is reused
    for (int i = 0; i < 16; i++) aw_issue(8'(i), 8'(i));
    slv_aw_valid = 1; slv_aw_id = 8'h40; mst_aw_ready = 1;
    exp_b_q.push_back(8'h05);
    mst_b_valid = 1; mst_b_id = 4'd5; slv_b_ready = 1;
    #1;
    aw_stall_chk("t3_full");
    check("t3_b_id", slv_b_id, exp_b_q.pop_front());
    @(negedge clk);
    mst_b_valid = 0; slv_b_ready = 0;
    exp_q.push_back(8'h05);
    #1;
    check("t3_reissue_ready", slv_aw_ready, 1);
    check("t3_reissue_id", {4'h0, mst_aw_id}, exp_q.pop_front());
    @(negedge clk);
    slv_aw_valid = 0; mst_aw_ready = 0;
    for (int i = 0; i < 16; i++) b_ret(4'(i), (i == 5) ? 8'h40 : 8'(i));
    busy_chk("t3_busy_off", 0);

    // 4: per-ID transaction limit
    for (int i = 0; i < 8; i++) aw_issue(8'h33, 0);
    slv_aw_valid = 1; slv_aw_id = 8'h33; mst_aw_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      aw_stall_chk("t4_limit");
      @(negedge clk);
    end
    exp_b_q.push_back(8'h33);
    mst_b_valid = 1; mst_b_id = 4'd0; slv_b_ready = 1;
    #1;
    aw_stall_chk("t4_limit_b");
    check("t4_b_id", slv_b_id, exp_b_q.pop_front());
    @(negedge clk);
    mst_b_valid = 0; slv_b_ready = 0;
    exp_q.push_back(8'h00);
    #1;
    check("t4_reissue_ready", slv_aw_ready, 1);
    check("t4_reissue_id", {4'h0, mst_aw_id}, exp_q.pop_front());
    @(negedge clk);
    slv_aw_valid = 0; mst_aw_ready = 0;
    for (int i = 0; i < 8; i++) b_ret(0, 8'h33);
    busy_chk("t4_busy_off", 0);

    // 5: issue and retire on the same entry in one cycle
    aw_issue(8'hE0, 0);
    aw_issue(8'hE1, 1);
    aw_issue(8'hE2, 2);
    aw_issue(8'h77, 3);
    exp_q.push_back(8'h03);
    exp_b_q.push_back(8'h77);
    slv_aw_valid = 1; slv_aw_id = 8'h77; mst_aw_ready = 1;
    mst_b_valid = 1; mst_b_id = 4'd3; slv_b_ready = 1;
    #1;
    check("t5_aw_ready", slv_aw_ready, 1);
    check("t5_aw_id", {4'h0, mst_aw_id}, exp_q.pop_front());
    check("t5_b_id", slv_b_id, exp_b_q.pop_front());
    @(negedge clk);
    clear_inputs();
    b_ret(0, 8'hE0);
    b_ret(1, 8'hE1);
    b_ret(2, 8'hE2);
    busy_chk("t5_entry3_kept", 1);
    b_ret(3, 8'h77);
    busy_chk("t5_busy_off", 0);

    // 6: read burst retires only on the last beat
    ar_issue(8'h9C, 0);
    for (int i = 0; i < 3; i++) begin
      r_beat(0, 0, 8'h9C);
      busy_chk("t6_busy_mid", 1);
    end
    r_beat(0, 1, 8'h9C);
    busy_chk("t6_busy_off", 0);

    // 6b: reset in the middle of a burst
    ar_issue(8'h9C, 0);
    r_beat(0, 0, 8'h9C);
    slv_ar_valid = 1; slv_ar_id = 8'h9C; mst_ar_ready = 1;
    mst_r_valid = 1; mst_r_id = 4'd0; slv_r_ready = 1;
    slv_aw_valid = 1; slv_aw_id = 8'h9C; mst_aw_ready = 1;
    rst = 1;
    #1;
    check("t6_rst_ar_valid", mst_ar_valid, 0);
    check("t6_rst_ar_ready", slv_ar_ready, 0);
    check("t6_rst_r_valid", slv_r_valid, 0);
    check("t6_rst_r_ready", mst_r_ready, 0);
    aw_stall_chk("t6_rst_aw");
    check("t6_rst_busy", busy, 0);
    @(negedge clk);
    clear_inputs();
    rst = 0;
    @(negedge clk);
    busy_chk("t6_post_rst_busy", 0);
    ar_issue(8'h5A, 0);   // table cleared: new ID lands on entry 0
    r_beat(0, 1, 8'h5A);
    busy_chk("t6_final_busy", 0);

    // Random: fresh table, IDs from a small pool so repeats share entries.
    begin
      int n;
      n = $urandom_range(6, 3);
      for (int k = 0; k < n; k++) begin
        logic [7:0] id;
        int idx;
        id = 8'h60 + 8'($urandom_range(3, 0));
        idx = -1;
        foreach (seen[j]) if (seen[j] == id && idx < 0) idx = j;
        if (idx < 0) begin
          seen.push_back(id);
          idx = seen.size() - 1;
        end
        rid_q.push_back(id);
        ridx_q.push_back(8'(idx));
        aw_issue(id, 8'(idx));
      end
      busy_chk("rnd_busy_on", 1);
      while (rid_q.size() > 0) begin
        logic [7:0] id, ix;
        id = rid_q.pop_front();
        ix = ridx_q.pop_front();
        b_ret(ix[3:0], id);
      end
      busy_chk("rnd_busy_off", 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pcie_axi_id_remapper.md
Name: pcie_axi_id_remapper

Overview:
- Bidirectional AXI ID width adapter for the PCIe bridge path, placed between the SoC-side AXI port (wide IDs) and the XDMA AXI port (narrow IDs).
- Handles the ID-downsizing case with a per-direction remap table of outstanding transactions.
- Handles the upsizing case by zero-extension and truncation.
- Operates on ID fields and channel handshakes only; the surrounding wrapper routes the payload fields straight through.

Parameters:
- SlvIdWidth, 8, ID width on the SoC side.
- MstIdWidth, 4, ID width on the PCIe side.
- MaxUniqIds, 16, remap table entries per direction; must be ≤ 2**MstIdWidth.
- MaxTxnsPerId, 8, maximum outstanding transactions sharing one table entry.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- slv_aw_valid_i  in  1; slv_aw_ready_o  out  1; slv_aw_id_i  in  SlvIdWidth.
- mst_aw_valid_o  out  1; mst_aw_ready_i  in  1; mst_aw_id_o  out  MstIdWidth.
- mst_b_valid_i  in  1; mst_b_ready_o  out  1; mst_b_id_i  in  MstIdWidth.
- slv_b_valid_o  out  1; slv_b_ready_i  in  1; slv_b_id_o  out  SlvIdWidth.
- slv_ar_valid_i / slv_ar_ready_o / slv_ar_id_i: as AW.
- mst_ar_valid_o / mst_ar_ready_i / mst_ar_id_o: as AW.
- mst_r_valid_i  in  1; mst_r_ready_o  out  1; mst_r_id_i  in  MstIdWidth; mst_r_last_i  in  1.
- slv_r_valid_o  out  1; slv_r_ready_i  in  1; slv_r_id_o  out  SlvIdWidth.
- busy_o  out  1  any entry in use in either table.

Behaviour:
- Mode selection at elaboration:
  - SlvIdWidth ≤ MstIdWidth → passthrough. No tables. Outgoing ID is zero-extended; returned ID is the low SlvIdWidth bits. All handshakes are wires. busy_o=0.
  - Otherwise → remap mode, described below.
- Table entry (write and read tables, identical and independent):
  - Fields: used (1 bit), slv_id (SlvIdWidth), cnt (clog2(MaxTxnsPerId+1)).
  - Master ID equals the entry index.
- Reset (rst_i high, asynchronous): all used=0, all cnt=0. While rst_i is high, all *_valid_o and *_ready_o are forced to 0 and busy_o=0.
- Issue decision is combinational on registered table state:
  - Hit: a used entry with slv_id == request ID. If cnt < MaxTxnsPerId, issue on that index; else stall.
  - Never allocate a second entry for an ID that already hits. This preserves same-ID ordering.
  - Miss: allocate the lowest-index free entry. If none is free, stall.
  - Issuing: mst_aw_valid_o = slv_aw_valid_i & can_issue; slv_aw_ready_o = mst_aw_ready_i & can_issue; mst_aw_id_o = chosen index. Zero added latency.
  - Stalled: mst_aw_valid_o=0 and slv_aw_ready_o=0.
  - Master valid never depends on master ready.
- On an AW handshake: cnt[idx]++. On allocation, additionally set used and write slv_id.
- B path:
  - slv_b_valid_o = mst_b_valid_i; mst_b_ready_o = slv_b_ready_i; slv_b_id_o = table[mst_b_id_i].slv_id.
  - On a B handshake: cnt--. When cnt reaches 0, clear used.
- R path: same as B, but the decrement happens only on a handshake with mst_r_last_i=1. Non-last beats leave the table untouched.
- Simultaneous issue and retire on the same entry: cnt is net unchanged.
  - If cnt was 1, the entry stays used with the same slv_id.
- An entry freed in cycle N becomes allocatable in cycle N+1; the lookup uses registered state.
- Error conditions (covered by simulation assertions; RTL behaviour undefined):
  - B or R returned for an unused entry.
  - cnt underflow.
  - MaxUniqIds > 2**MstIdWidth.
- busy_o = OR of all used bits in both tables, registered view.

Test Plan:
1. AW id 0xA5, mst ready=1 → mst_aw_id_o=0, entry0 cnt=1. B with id 0 → slv_b_id_o=0xA5, entry0 freed, busy_o=0 next cycle.
2. Two AWs with id 0x11, then one with id 0x22 → mst IDs 0, 0, 1; entry0 cnt=2. Two B id 0 → entry0 freed only after the second.
3. Sixteen distinct IDs 0x00..0x0F issued → 17th ID 0x40 stalls (slv_aw_ready_o=0, mst_aw_valid_o=0). B on id 5 → 0x40 issues next cycle with mst_aw_id_o=5.
4. Nine AWs with id 0x33 and no B → 9th stalls while the other 15 entries are free. One B → 9th issues on the same index.
5. Entry3 holds 0x77 with cnt=1; in one cycle B id 3 and AW id 0x77 both handshake → entry3 still used, cnt=1, slv_id=0x77.
6. AR id 0x9C issues a 4-beat read → beats 1-3 keep cnt=1, beat 4 (last) frees the entry; all four beats carry slv_r_id_o=0x9C. Assert rst_i mid-burst → outputs 0, tables cleared.
7. Optional: SlvIdWidth=4, MstIdWidth=6 → AW id 0xB maps to 0x0B; B id 0x0B returns 0xB.
